// File: rtl/plic_ahb_bridge.sv
// AHB-Lite slave front end for the PLIC register file (or any register-mapped
// peripheral). It runs a data-phase engine that inserts backend wait states,
// aborts a stalled backend after TIMEOUT busy cycles, and answers bad accesses
// with the two-cycle AHB ERROR response.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   HSEL .. HREADY   AHB-Lite slave address/data-phase inputs
//   HRDATA           read data (registered, held until the next read completes)
//   HREADYOUT, HRESP slave ready / error response
//   bus_req          backend access active (one per accepted, legal transfer)
//   bus_wen          1 = write, 0 = read; valid with bus_req
//   bus_addr         byte offset from BASE_ADDR
//   bus_wdata        write data (HWDATA passed through during the access)
//   bus_strb         byte enables
//   bus_rdata        backend read data, taken when bus_req=1 and bus_busy=0
//   bus_busy         backend stall
//   bus_abort        one-cycle pulse when the backend stalls for too long
module plic_ahb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h8004_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_1000,
  parameter int          DATA_W    = 32,
  parameter int          TIMEOUT   = 16,
  parameter int          OFFSET_W  = $clog2(ADDR_SPAN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_W-1:0]     HWDATA,
  input  logic                  HREADY,
  output logic [DATA_W-1:0]     HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  bus_req,
  output logic                  bus_wen,
  output logic [OFFSET_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_strb,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_busy,
  output logic                  bus_abort
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RDONE,
    S_ERR1,
    S_ERR2
  } state_t;

  // Saturating increment: the busy counter must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  // Byte lanes covered by a transfer of 2**size bytes starting at lane lo.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [LANE_W-1:0] lo,
                                                  input logic [2:0]        size);
    logic [STRB_W-1:0] s;
    int nb;
    nb = 1 << size;
    s  = '0;
    for (int i = 0; i < STRB_W; i++) begin
      s[i] = (i >= int'(lo)) && (i < int'(lo) + nb);
    end
    return s;
  endfunction

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 capture;
  logic                 rd_load;

  logic [OFFSET_W-1:0]  addr_p0;
  logic                 wen_p0;
  logic [2:0]           size_p0;

  logic                 accept;
  logic                 bad;
  logic [31:0]          offset;
  logic [31:0]          amask;

  // Address-phase decode
  assign accept = HSEL & HREADY & HTRANS[1];
  assign offset = HADDR - BASE_ADDR;
  assign amask  = (32'd1 << HSIZE) - 32'd1;
  assign bad    = (HADDR < BASE_ADDR) || (offset >= ADDR_SPAN) ||
                  (HSIZE > 3'(LANE_W)) || (|(HADDR & amask));

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    capture   = 1'b0;
    rd_load   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    bus_req   = 1'b0;
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_strb  = '0;
    bus_abort = 1'b0;

    case (state)
      S_IDLE, S_RDONE: begin
        state_d = S_IDLE;
        capture = accept;
      end
      S_ACCESS: begin
        bus_req   = 1'b1;
        bus_wen   = wen_p0;
        bus_addr  = addr_p0;
        bus_wdata = HWDATA;
        bus_strb  = lane_strb(addr_p0[LANE_W-1:0], size_p0);
        if (bus_busy) begin
          HREADYOUT = 1'b0;
          cnt_d     = sat_inc(cnt);
          // This busy cycle is the TIMEOUT-th one: give up on the backend.
          if (cnt >= CNT_LAST) begin
            bus_abort = 1'b1;
            state_d   = S_ERR1;
          end
        end else if (wen_p0) begin
          // Write completes with zero wait, so the next transfer may pipeline in.
          state_d = S_IDLE;
          capture = accept;
        end else begin
          // Read data is registered, costing one wait state.
          HREADYOUT = 1'b0;
          rd_load   = 1'b1;
          state_d   = S_RDONE;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP   = 1'b1;
        state_d = S_IDLE;
        capture = accept;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      state_d = bad ? S_ERR1 : S_ACCESS;
      if (!bad) begin
        cnt_d = '0;
      end
    end
  end

  // Control state and read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      HRDATA <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (rd_load) begin
        HRDATA <= bus_rdata;
      end
    end
  end

  // Address-phase capture (p0): only read while in ACCESS, which always
  // follows a capture, so these need no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_p0 <= offset[OFFSET_W-1:0];
      wen_p0  <= HWRITE;
      size_p0 <= HSIZE;
    end
  end

endmodule

// File: tb/tb_plic_ahb_bridge.sv
// Self-checking bench for plic_ahb_bridge: directed transfers push their
// expected AHB response and backend access into queues; a monitor on the
// falling edge pops and compares when the DUT completes a data phase or a
// backend access.
module tb_plic_ahb_bridge;

  logic        clk;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        bus_req;
  logic        bus_wen;
  logic [11:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic [31:0] bus_rdata;
  logic        bus_busy;
  logic        bus_abort;

  plic_ahb_bridge dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_rdata(bus_rdata),
    .bus_busy(bus_busy), .bus_abort(bus_abort)
  );

  // Single slave on the bus: the bus-wide ready is this slave's ready.
  assign HREADY = HREADYOUT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          rd;
    logic [31:0] rdata;
    bit          resp;
    int          waits;
  } resp_t;

  typedef struct {
    int          tag;
    bit          wen;
    logic [11:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          cyc;
    bit          abort;
  } be_t;

  resp_t rq[$];
  be_t   bq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int tag_n  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit dp_act = 0;
  int dp_wait = 0;
  int be_cyc = 0;
  bit be_abort_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      dp_act = 0;
      dp_wait = 0;
      be_cyc = 0;
    end else begin
      if (dp_act) begin
        if (HREADYOUT) begin
          if (rq.size() == 0) begin
            chk("unexpected data phase", 1, 0);
          end else begin
            resp_t r;
            r = rq.pop_front();
            chk($sformatf("resp[%0d] HRESP", r.tag), HRESP, r.resp);
            chk($sformatf("resp[%0d] waits", r.tag), dp_wait, r.waits);
            if (r.rd) chk($sformatf("resp[%0d] HRDATA", r.tag), HRDATA, r.rdata);
          end
          dp_act = 0;
        end else begin
          dp_wait++;
        end
      end
      if (HSEL && HREADY && HTRANS[1]) begin
        dp_act = 1;
        dp_wait = 0;
      end
      if (bus_req) begin
        be_cyc++;
        if (!bus_busy || bus_abort) begin
          if (bq.size() == 0) begin
            chk("unexpected bus_req", 1, 0);
          end else begin
            be_t b;
            b = bq.pop_front();
            chk($sformatf("be[%0d] bus_wen", b.tag), bus_wen, b.wen);
            chk($sformatf("be[%0d] bus_addr", b.tag), bus_addr, b.addr);
            chk($sformatf("be[%0d] bus_strb", b.tag), bus_strb, b.strb);
            if (b.wen) chk($sformatf("be[%0d] bus_wdata", b.tag), bus_wdata, b.wdata);
            chk($sformatf("be[%0d] cycles", b.tag), be_cyc, b.cyc);
            chk($sformatf("be[%0d] bus_abort", b.tag), bus_abort, b.abort);
          end
          be_cyc = 0;
        end
      end else if (bus_abort) begin
        chk("bus_abort without bus_req", bus_abort, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input bit w, input logic [2:0] s);
    int guard;
    @(posedge clk); #2;
    HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = s; HTRANS = 2'b10;
    bus_busy = 1'b0;
    guard = 0;
    forever begin
      @(negedge clk);
      if (HREADY) break;
      guard++;
      if (guard > 50) begin
        chk("address phase HREADY timeout", 0, 1);
        break;
      end
      @(posedge clk); #2;
    end
  endtask

  // Single transfer: address phase, then data phase with n busy cycles.
  task automatic xfer(input logic [31:0] a, input bit w, input logic [2:0] s,
                      input logic [31:0] d, input int n);
    int k;
    addr_phase(a, w, s);
    @(posedge clk); #2;
    idle_bus();
    HWDATA = d; bus_rdata = d; k = 0; bus_busy = (k < n);
    forever begin
      @(negedge clk);
      if (HREADYOUT) break;
      k++;
      if (k > 60) begin
        chk("data phase completion timeout", 0, 1);
        break;
      end
      @(posedge clk); #2;
      bus_busy = (k < n);
    end
  endtask

  task automatic exp_resp(input bit rd, input logic [31:0] rdata, input bit resp, input int waits);
    resp_t r;
    r.tag = tag_n; r.rd = rd; r.rdata = rdata; r.resp = resp; r.waits = waits;
    rq.push_back(r);
  endtask

  task automatic exp_be(input bit wen, input logic [11:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input int cyc, input bit abort);
    be_t b;
    b.tag = tag_n; b.wen = wen; b.addr = addr; b.strb = strb; b.wdata = wdata;
    b.cyc = cyc; b.abort = abort;
    bq.push_back(b);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, " HREADYOUT"}, HREADYOUT, 1);
    chk({pfx, " HRESP"}, HRESP, 0);
    chk({pfx, " HRDATA"}, HRDATA, 0);
    chk({pfx, " bus_req"}, bus_req, 0);
    chk({pfx, " bus_wen"}, bus_wen, 0);
    chk({pfx, " bus_addr"}, bus_addr, 0);
    chk({pfx, " bus_strb"}, bus_strb, 0);
    chk({pfx, " bus_abort"}, bus_abort, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    idle_bus();
    HWDATA = 32'h0; bus_rdata = 32'h0; bus_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    // Word write, zero wait
    tag_n = 1; exp_resp(0, 0, 0, 0); exp_be(1, 12'h004, 4'hF, 32'hDEADBEEF, 1, 0);
    xfer(32'h8004_0004, 1, 3'd2, 32'hDEADBEEF, 0);

    // Word read, one wait
    tag_n = 2; exp_resp(1, 32'h0000_0007, 0, 1); exp_be(0, 12'h200, 4'hF, 0, 1, 0);
    xfer(32'h8004_0200, 0, 3'd2, 32'h0000_0007, 0);

    // Byte write on lane 3 with a 3-cycle stall
    tag_n = 3; exp_resp(0, 0, 0, 3); exp_be(1, 12'h003, 4'b1000, 32'hAB00_0000, 4, 0);
    xfer(32'h8004_0003, 1, 3'd0, 32'hAB00_0000, 3);

    // Halfword read on lanes 2-3 with a 2-cycle stall
    tag_n = 4; exp_resp(1, 32'h1234_0000, 0, 3); exp_be(0, 12'h006, 4'b1100, 0, 3, 0);
    xfer(32'h8004_0006, 0, 3'd1, 32'h1234_0000, 2);

    // Bad accesses: out of span, misaligned, below base, oversized
    tag_n = 5; exp_resp(0, 0, 1, 1); xfer(32'h8004_1000, 1, 3'd2, 32'h1, 0);
    tag_n = 6; exp_resp(0, 0, 1, 1); xfer(32'h8004_0002, 1, 3'd2, 32'h2, 0);
    tag_n = 7; exp_resp(1, 32'h1234_0000, 1, 1); xfer(32'h8003_FFFC, 0, 3'd2, 32'h3, 0);
    tag_n = 8; exp_resp(0, 0, 1, 1); xfer(32'h8004_0008, 1, 3'd3, 32'h4, 0);

    // Back-to-back: write A, write B, read C pipelined
    tag_n = 9;  exp_resp(0, 0, 0, 0); exp_be(1, 12'h020, 4'hF, 32'h1111_1111, 1, 0);
    tag_n = 10; exp_resp(0, 0, 0, 0); exp_be(1, 12'h024, 4'hF, 32'h2222_2222, 1, 0);
    tag_n = 11; exp_resp(1, 32'h3333_3333, 0, 1); exp_be(0, 12'h028, 4'hF, 0, 1, 0);
    addr_phase(32'h8004_0020, 1, 3'd2);
    @(posedge clk); #2;
    HADDR = 32'h8004_0024; HWDATA = 32'h1111_1111; bus_busy = 1'b0;
    @(posedge clk); #2;
    HADDR = 32'h8004_0028; HWRITE = 1'b0; HWDATA = 32'h2222_2222;
    @(posedge clk); #2;
    idle_bus(); bus_rdata = 32'h3333_3333;
    repeat (2) @(posedge clk);

    // IDLE transfer type with HSEL: no data phase, OKAY, no backend access
    #2;
    HSEL = 1'b1; HADDR = 32'h8004_0030; HTRANS = 2'b00; HWRITE = 1'b1; HSIZE = 3'd2;
    @(negedge clk);
    chk("idle-trans HREADYOUT", HREADYOUT, 1);
    @(negedge clk);
    chk("idle-trans bus_req", bus_req, 0);
    chk("idle-trans HRESP", HRESP, 0);
    @(posedge clk); #2;
    idle_bus();

    // Timeout: backend stuck busy, abort on the 16th busy cycle then ERROR
    tag_n = 12; exp_resp(0, 0, 1, 17); exp_be(1, 12'h010, 4'hF, 32'hCAFE_0010, 16, 1);
    xfer(32'h8004_0010, 1, 3'd2, 32'hCAFE_0010, 100);

    // Next transfer after the abort completes normally
    tag_n = 13; exp_resp(0, 0, 0, 0); exp_be(1, 12'h014, 4'hF, 32'h0000_0014, 1, 0);
    xfer(32'h8004_0014, 1, 3'd2, 32'h0000_0014, 0);

    // Reset in the middle of a stalled read
    addr_phase(32'h8004_0100, 0, 3'd2);
    @(posedge clk); #2;
    idle_bus(); bus_busy = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid-read reset");
    @(posedge clk); #2;
    bus_busy = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;

    // First transfer after reset release
    tag_n = 14; exp_resp(1, 32'h55AA_55AA, 0, 1); exp_be(0, 12'h008, 4'hF, 0, 1, 0);
    xfer(32'h8004_0008, 0, 3'd2, 32'h55AA_55AA, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pending responses", rq.size(), 0);
    chk("pending backend accesses", bq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
